td4_prog_loader: RTL

Program store and loader that sits directly upstream of the TD4 core. It holds the 16 x 8-bit program and supplies `CMD`/`DATA` for the core's current `regPC` with ROM semantics. It accepts a new program over a byte-wide valid/ready load port and holds the core in reset until a complete, optionally checksum-verified, image is in place.

---
 rtl/td4_prog_loader.sv | 108 ++++++++++
 1 files changed

// File: rtl/td4_prog_loader.sv
// TD4 program store: 16x8 ROM-style read port for the core plus a byte-wide loader.
// Define TD4_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte per image.
module td4_prog_loader (
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] pc,
   output logic [3:0] cmd,
   output logic [3:0] data,
   output logic       cpu_clr,
   input  logic       ld_start,
   input  logic       ld_valid,
   output logic       ld_ready,
   input  logic [7:0] ld_data,
   output logic [3:0] ld_addr,
   output logic       busy,
   output logic       loaded,
   output logic       err
);

`ifdef TD4_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {StEmpty, StLoad, StCheck, StRun, StErr} state_e;
   logic [7:0] sum;
`else
   typedef enum logic [2:0] {StEmpty, StLoad, StRun} state_e;
`endif

   state_e     state;
   logic [7:0] mem [16];
   logic       xfer;

   assign xfer = ld_valid && ld_ready;

   // Combinational read: a same-cycle write is seen only after its edge.
   assign cmd  = mem[pc][7:4];
   assign data = mem[pc][3:0];

`ifndef TD4_LOADER_CHECKSUM_EN
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= StEmpty;
         for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
         ld_addr  <= 4'd0;
         cpu_clr  <= 1'b0;
         ld_ready <= 1'b0;
         busy     <= 1'b0;
         loaded   <= 1'b0;
`ifdef TD4_LOADER_CHECKSUM_EN
         err      <= 1'b0;
         sum      <= 8'h00;
`endif
      end else begin
         // One cycle behind the state so the core sees reset after the last byte.
         cpu_clr <= (state == StRun);
         if (ld_start) begin
            // Restart from any state; a coincident transfer is dropped.
            state    <= StLoad;
            ld_addr  <= 4'd0;
            ld_ready <= 1'b1;
            busy     <= 1'b1;
            loaded   <= 1'b0;
`ifdef TD4_LOADER_CHECKSUM_EN
            err      <= 1'b0;
            sum      <= 8'h00;
`endif
         end else begin
            case (state)
               StLoad: begin
                  if (xfer) begin
                     mem[ld_addr] <= ld_data;
                     ld_addr      <= ld_addr + 4'd1;
`ifdef TD4_LOADER_CHECKSUM_EN
                     sum          <= sum + ld_data;
                     if (ld_addr == 4'd15) state <= StCheck;
`else
                     if (ld_addr == 4'd15) begin
                        state    <= StRun;
                        ld_ready <= 1'b0;
                        busy     <= 1'b0;
                        loaded   <= 1'b1;
                     end
`endif
                  end
               end
`ifdef TD4_LOADER_CHECKSUM_EN
               StCheck: begin
                  if (xfer) begin
                     ld_ready <= 1'b0;
                     busy     <= 1'b0;
                     if (ld_data == sum) begin
                        state  <= StRun;
                        loaded <= 1'b1;
                     end else begin
                        state <= StErr;
                        err   <= 1'b1;
                     end
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule
